// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one half double-round (four parallel quarter-rounds)
// per cycle, followed by a feed-forward cycle that also advances the block counter.
module chacha_block_core #(
  parameter int ROUNDS     = 20,
  parameter bit COUNTER_64 = 1'b0,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        ctr_wrap,
  output logic [1:0]  dbg_state
);

  // Handshake: start is accepted only in IDLE; busy rises the cycle after and stays high
  // for ROUNDS+1 cycles; done pulses for one cycle as busy falls, and a new start in that
  // cycle is accepted. wr_en and start are ignored while busy.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         rnd_q, rnd_d;
  logic [15:0][31:0]  in_q, in_d;
  logic [15:0][31:0]  wk_q, wk_d;
  logic [15:0][31:0]  out_q, out_d;
  logic [15:0][31:0]  rnd_w;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ctr_wrap_q, ctr_wrap_d;

  logic [31:0]        ctr_lo_inc;
  logic [31:0]        ctr_hi_inc;
  logic               ctr_carry;
  logic               wrap_hit;

  function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                      input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i;
    b = b_i;
    c = c_i;
    d = d_i;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Even round index -> column round, odd -> diagonal round.
  always_comb begin
    rnd_w = wk_q;
    if (!rnd_q[0]) begin
      {rnd_w[0], rnd_w[4], rnd_w[8],  rnd_w[12]} = qr(wk_q[0], wk_q[4], wk_q[8],  wk_q[12]);
      {rnd_w[1], rnd_w[5], rnd_w[9],  rnd_w[13]} = qr(wk_q[1], wk_q[5], wk_q[9],  wk_q[13]);
      {rnd_w[2], rnd_w[6], rnd_w[10], rnd_w[14]} = qr(wk_q[2], wk_q[6], wk_q[10], wk_q[14]);
      {rnd_w[3], rnd_w[7], rnd_w[11], rnd_w[15]} = qr(wk_q[3], wk_q[7], wk_q[11], wk_q[15]);
    end else begin
      {rnd_w[0], rnd_w[5], rnd_w[10], rnd_w[15]} = qr(wk_q[0], wk_q[5], wk_q[10], wk_q[15]);
      {rnd_w[1], rnd_w[6], rnd_w[11], rnd_w[12]} = qr(wk_q[1], wk_q[6], wk_q[11], wk_q[12]);
      {rnd_w[2], rnd_w[7], rnd_w[8],  rnd_w[13]} = qr(wk_q[2], wk_q[7], wk_q[8],  wk_q[13]);
      {rnd_w[3], rnd_w[4], rnd_w[9],  rnd_w[14]} = qr(wk_q[3], wk_q[4], wk_q[9],  wk_q[14]);
    end
  end

  always_comb begin
    ctr_lo_inc = in_q[12] + 32'd1;
    ctr_carry  = (in_q[12] == 32'hffff_ffff);
    ctr_hi_inc = in_q[13] + {31'd0, ctr_carry};
    if (COUNTER_64) begin
      wrap_hit = (ctr_lo_inc == 32'd0) && (ctr_hi_inc == 32'd0);
    end else begin
      wrap_hit = (ctr_lo_inc == 32'd0);
    end
  end

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    in_d       = in_q;
    wk_d       = wk_q;
    out_d      = out_q;
    done_d     = 1'b0;
    ctr_wrap_d = ctr_wrap_q;
    rd_data_d  = out_q[rd_addr];

    case (state_q)
      S_IDLE: begin
        // The write is applied before the copy so a same-cycle word joins this block.
        if (wr_en) begin
          in_d[wr_addr] = wr_data;
          if (wr_addr == 4'd12 || (COUNTER_64 && wr_addr == 4'd13)) begin
            ctr_wrap_d = 1'b0;
          end
        end
        if (start) begin
          wk_d    = in_d;
          rnd_d   = 8'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        wk_d  = rnd_w;
        rnd_d = rnd_q + 8'd1;
        if (rnd_q == 8'(ROUNDS - 1)) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int i = 0; i < 16; i++) begin
          out_d[i] = wk_q[i] + in_q[i];
        end
        if (AUTO_INC) begin
          in_d[12] = ctr_lo_inc;
          if (COUNTER_64) begin
            in_d[13] = ctr_hi_inc;
          end
          if (wrap_hit) begin
            ctr_wrap_d = 1'b1;
          end
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rnd_q      <= 8'd0;
      in_q       <= '0;
      wk_q       <= '0;
      out_q      <= '0;
      rd_data_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ctr_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      in_q       <= in_d;
      wk_q       <= wk_d;
      out_q      <= out_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ctr_wrap_q <= ctr_wrap_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ctr_wrap  = ctr_wrap_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Bench for chacha_block_core: a 32-bit-counter and a 64-bit-counter instance share the
// same stimulus and are compared every cycle against a block-level ChaCha reference.
module tb_chacha_block_core;

  localparam int ROUNDS = 20;
  typedef logic [31:0] blk_t [16];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic        start = 1'b0;
  logic [3:0]  rd_addr = 4'd0;

  logic [31:0] rd_data0, rd_data1;
  logic        busy0, busy1, done0, done1, wrap0, wrap1;
  logic [1:0]  dbg0, dbg1;

  always #5 clk = ~clk;

  chacha_block_core #(.ROUNDS(ROUNDS), .COUNTER_64(1'b0), .AUTO_INC(1'b1)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0), .done(done0),
    .ctr_wrap(wrap0), .dbg_state(dbg0)
  );

  chacha_block_core #(.ROUNDS(ROUNDS), .COUNTER_64(1'b1), .AUTO_INC(1'b1)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data1), .busy(busy1), .done(done1),
    .ctr_wrap(wrap1), .dbg_state(dbg1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int qidx [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                      '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic void chacha_ref(input blk_t s, output blk_t res);
    blk_t x;
    int a, b, c, d;
    x = s;
    for (int r = 0; r < ROUNDS; r++) begin
      for (int q = 0; q < 4; q++) begin
        a = qidx[(r % 2) * 4 + q][0];
        b = qidx[(r % 2) * 4 + q][1];
        c = qidx[(r % 2) * 4 + q][2];
        d = qidx[(r % 2) * 4 + q][3];
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) res[i] = x[i] + s[i];
  endfunction

  blk_t        m_in [2];
  blk_t        m_out [2];
  logic        m_wrap [2];
  logic [31:0] m_rd [2];
  int          remaining = 0;
  logic        exp_done = 1'b0;
  logic        exp_busy = 1'b0;

  initial begin
    blk_t tmp;
    logic [63:0] c64;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int m = 0; m < 2; m++) begin
          for (int i = 0; i < 16; i++) begin
            m_in[m][i] = 32'd0;
            m_out[m][i] = 32'd0;
          end
          m_wrap[m] = 1'b0;
          m_rd[m] = 32'd0;
        end
        remaining = 0;
        exp_done = 1'b0;
        exp_busy = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) m_rd[m] = m_out[m][rd_addr];
        exp_done = 1'b0;
        if (remaining == 0) begin
          if (wr_en) begin
            for (int m = 0; m < 2; m++) begin
              m_in[m][wr_addr] = wr_data;
              if (wr_addr == 4'd12 || (m == 1 && wr_addr == 4'd13)) m_wrap[m] = 1'b0;
            end
          end
          if (start) remaining = ROUNDS + 1;
        end else begin
          remaining--;
          if (remaining == 0) begin
            for (int m = 0; m < 2; m++) begin
              chacha_ref(m_in[m], tmp);
              m_out[m] = tmp;
            end
            m_in[0][12] = m_in[0][12] + 32'd1;
            if (m_in[0][12] == 32'd0) m_wrap[0] = 1'b1;
            c64 = {m_in[1][13], m_in[1][12]} + 64'd1;
            {m_in[1][13], m_in[1][12]} = c64;
            if (c64 == 64'd0) m_wrap[1] = 1'b1;
            exp_done = 1'b1;
          end
        end
        exp_busy = (remaining != 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check32("busy32", {31'd0, busy0}, {31'd0, exp_busy});
      check32("done32", {31'd0, done0}, {31'd0, exp_done});
      check32("wrap32", {31'd0, wrap0}, {31'd0, m_wrap[0]});
      check32("rd32", rd_data0, m_rd[0]);
      check32("busy64", {31'd0, busy1}, {31'd0, exp_busy});
      check32("done64", {31'd0, done1}, {31'd0, exp_done});
      check32("wrap64", {31'd0, wrap1}, {31'd0, m_wrap[1]});
      check32("rd64", rd_data1, m_rd[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_block(input blk_t s);
    for (int i = 0; i < 16; i++) write_word(4'(i), s[i]);
  endtask

  // Waits for done; at cycle inj (if >=1) fires a write to word 4 plus a stray start.
  task automatic wait_done(input int inj, input int lat0, output int lat);
    lat = lat0;
    while (!done0 && lat < 100) begin
      rd_addr = 4'($urandom_range(0, 15));
      if (lat == inj) begin
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = $urandom; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    wr_en = 1'b0; start = 1'b0;
    checks++;
    if (!done0) begin
      errors++;
      $display("FAIL done_timeout act=no_done req=done_within_100_cycles");
    end
  endtask

  task automatic run_block(input int inj, output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(inj, 0, lat);
  endtask

  task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_addr = a;
    @(negedge clk);
    check32(name, rd_data0, exp);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    blk_t rfc, zero_blk, rnd_blk, res;
    int lat, dones;

    rfc = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
            32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
            32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
            32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    zero_blk = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check32("rst_busy", {31'd0, busy0}, 32'd0);
    check32("rst_done", {31'd0, done0}, 32'd0);
    check32("rst_wrap", {31'd0, wrap0}, 32'd0);
    check32("rst_rd", rd_data0, 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Pin the reference against published vectors
    chacha_ref(rfc, res);
    check32("model_rfc_w0", res[0], 32'he4e7f110);
    check32("model_rfc_w1", res[1], 32'h15593bd1);
    check32("model_rfc_w2", res[2], 32'h1fdd0f50);
    check32("model_rfc_w3", res[3], 32'hc47120a3);
    chacha_ref(zero_blk, res);
    check32("model_a1_w0", res[0], 32'hade0b876);
    check32("model_a1_w1", res[1], 32'h903df1a0);

    // RFC block, latency and readback
    load_block(rfc);
    run_block(-1, lat);
    check32("rfc_latency", 32'(lat), 32'(ROUNDS + 1));
    check32("model_ctr_next", m_in[0][12], 32'd2);

    // Back-to-back start in the done cycle; reads still see the counter=1 block
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_addr = 4'd0;
    @(negedge clk);
    check32("b2b_old_w0", rd_data0, 32'he4e7f110);
    wait_done(-1, 1, lat);
    check32("b2b_latency", 32'(lat), 32'(ROUNDS + 1));
    sweep();

    // Writes and start while busy are ignored
    load_block(rfc);
    run_block(8, lat);
    check32("busy_latency", 32'(lat), 32'(ROUNDS + 1));
    read_check(4'd0, 32'he4e7f110, "busy_w0");
    read_check(4'd1, 32'h15593bd1, "busy_w1");
    read_check(4'd2, 32'h1fdd0f50, "busy_w2");
    read_check(4'd3, 32'hc47120a3, "busy_w3");
    check32("busy_word4_kept", m_in[0][4], 32'h03020100);
    run_block(-1, lat);
    sweep();

    // All-zero key/nonce/counter
    load_block(zero_blk);
    run_block(-1, lat);
    read_check(4'd0, 32'hade0b876, "a1_w0");
    read_check(4'd1, 32'h903df1a0, "a1_w1");

    // Counter wrap in both counter modes
    for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
    rnd_blk[12] = 32'hffffffff;
    rnd_blk[13] = 32'h00000005;
    load_block(rnd_blk);
    run_block(-1, lat);
    @(negedge clk);
    check32("wrap32_set", {31'd0, wrap0}, 32'd1);
    check32("wrap64_clear", {31'd0, wrap1}, 32'd0);
    check32("model32_w12", m_in[0][12], 32'd0);
    check32("model32_w13", m_in[0][13], 32'd5);
    check32("model64_w12", m_in[1][12], 32'd0);
    check32("model64_w13", m_in[1][13], 32'd6);
    run_block(-1, lat);
    sweep();
    write_word(4'd12, 32'h00000007);
    @(negedge clk);
    check32("wrap32_cleared", {31'd0, wrap0}, 32'd0);

    // Reset in the middle of the rounds
    load_block(rfc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check32("midrst_busy", {31'd0, busy0}, 32'd0);
    check32("midrst_done", {31'd0, done0}, 32'd0);
    check32("midrst_rd", rd_data0, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done0) dones++;
    end
    check32("midrst_no_done", 32'(dones), 32'd0);
    load_block(rfc);
    run_block(-1, lat);
    read_check(4'd0, 32'he4e7f110, "post_rst_w0");
    read_check(4'd3, 32'hc47120a3, "post_rst_w3");

    // Randomized blocks
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
      load_block(rnd_blk);
      run_block(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ROUNDS - 1)) : -1, lat);
      check32("rand_latency", 32'(lat), 32'(ROUNDS + 1));
      sweep();
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
